// File: rtl/sht10_pkg.sv
// -----------------------------------------------------------------------------
// sht10_pkg
// Shared definitions for the SHT10 responder slice: sensor address, command
// codes, CRC polynomial, FSM / start-detector encodings, datapath action codes
// and a bit-reverse helper used for the transmitted CRC byte.
// -----------------------------------------------------------------------------
package sht10_pkg;

  localparam logic [2:0] SHT_ADDR = 3'b000;
  localparam logic [4:0] CMD_TEMP = 5'b00011;
  localparam logic [4:0] CMD_RH   = 5'b00101;

  // x^8 + x^5 + x^4 + 1, x^8 term implicit
  localparam logic [7:0] CRC_POLY = 8'h31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_RX,
    ST_CMD_ACK,
    ST_MEAS,
    ST_TX,
    ST_TX_ACK
  } state_t;

  // Progress through the transmission-start pattern
  typedef enum logic [1:0] {
    SP_WAIT_SDA_FALL,
    SP_WAIT_SCK_FALL,
    SP_WAIT_SCK_RISE,
    SP_WAIT_SDA_RISE
  } start_phase_t;

  // One datapath action per clock, chosen by the next-state logic
  typedef enum logic [3:0] {
    ACT_NONE,
    ACT_START,
    ACT_SHIFT,
    ACT_ACCEPT,
    ACT_RELEASE,
    ACT_FIRST_BIT,
    ACT_NEXT_BIT,
    ACT_SAMPLE_ACK,
    ACT_NEXT_BYTE,
    ACT_FINISH
  } action_t;

  function automatic logic [7:0] reverse8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/sht10_crc8.sv
// -----------------------------------------------------------------------------
// sht10_crc8
// Serial CRC-8 (x^8+x^5+x^4+1), one message bit per enabled clock, MSB first,
// init 0x00. Usable by either end of the link.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous, active-high
//   clr    in  return register to 0x00 (wins over en)
//   en     in  absorb din this clock
//   din    in  message bit
//   crc    out current CRC register
// -----------------------------------------------------------------------------
module sht10_crc8
  import sht10_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic feedback;

  assign feedback = crc[7] ^ din;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ (feedback ? CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/sht10_responder.sv
// -----------------------------------------------------------------------------
// sht10_responder
// Sensor-side end of the SHT10 SCK/DATA link. Detects the transmission start,
// receives address+command, ACKs valid commands, waits MEAS_CYCLES, signals
// data-ready and shifts out MSB, LSB and CRC, honouring master ACKs. The pad
// tristate lives above this module: SDA = sda_drive_low ? 1'b0 : 1'bz.
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high
//   sck_in         in   SCK from master (asynchronous)
//   sda_in         in   DATA pin level (asynchronous, pulled up)
//   sda_drive_low  out  1 = pull DATA low, 0 = release
//   temp_value     in   raw temperature word (command 00011)
//   rh_value       in   raw humidity word (command 00101)
//   busy           out  command ACKed and read not yet finished
//   cmd_accepted   out  1-cycle pulse when a valid command is ACKed
//   xfer_done      out  1-cycle pulse when a read ends
// -----------------------------------------------------------------------------
module sht10_responder
  import sht10_pkg::*;
#(
  parameter logic [19:0] MEAS_CYCLES = 20'd5000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sck_in,
  input  logic        sda_in,
  output logic        sda_drive_low,
  input  logic [13:0] temp_value,
  input  logic [11:0] rh_value,
  output logic        busy,
  output logic        cmd_accepted,
  output logic        xfer_done
);

  // ---------------- input synchronizers and edge strobes ----------------
  logic [SYNC_STAGES-1:0] sck_sync, sda_sync;
  logic sck_s, sda_s, sck_prev, sda_prev;
  logic sck_rise, sck_fall, sck_edge, sda_rise, sda_fall;

  // NOTE: clocked state is always assigned with <=, so every register in a
  // block samples the pre-edge values and block order never matters.
  always_ff @(posedge clock) begin
    if (reset) begin
      // Idle line levels (SCK low, DATA pulled up) so reset creates no edges
      sck_sync <= '0;
      sda_sync <= '1;
      sck_prev <= 1'b0;
      sda_prev <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      sck_prev <= sck_s;
      sda_prev <= sda_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign sck_edge = sck_rise | sck_fall;
  // A DATA edge coincident with an SCK edge counts as data, not as start
  assign sda_rise = sda_s & ~sda_prev & ~sck_edge;
  assign sda_fall = ~sda_s & sda_prev & ~sck_edge;

  // ---------------- transmission-start detector ----------------
  start_phase_t sp_q, sp_d;
  logic         start_done;

  always_ff @(posedge clock) begin
    if (reset) sp_q <= SP_WAIT_SDA_FALL;
    else       sp_q <= sp_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    sp_d       = sp_q;
    start_done = 1'b0;
    case (sp_q)
      SP_WAIT_SDA_FALL:
        if (sda_fall && sck_s) sp_d = SP_WAIT_SCK_FALL;
      SP_WAIT_SCK_FALL:
        if (sck_fall)                 sp_d = SP_WAIT_SCK_RISE;
        else if (sda_rise || sda_fall) sp_d = SP_WAIT_SDA_FALL;
      SP_WAIT_SCK_RISE:
        if (sck_rise)                 sp_d = SP_WAIT_SDA_RISE;
        else if (sda_rise || sda_fall) sp_d = SP_WAIT_SDA_FALL;
      SP_WAIT_SDA_RISE:
        if (sda_rise) begin
          start_done = 1'b1;
          sp_d       = SP_WAIT_SDA_FALL;
        end else if (sck_edge || sda_fall) begin
          sp_d = SP_WAIT_SDA_FALL;
        end
      default: sp_d = SP_WAIT_SDA_FALL;
    endcase
  end

  // ---------------- main FSM ----------------
  state_t      state_q, state_d;
  action_t     act;
  logic [7:0]  cmd_sr;
  logic [3:0]  bit_cnt;
  logic [15:0] word_q;
  logic [1:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic        ack_level;
  logic [19:0] meas_cnt;
  logic        drive_q, accepted_q, done_q;
  logic        cmd_valid;

  assign cmd_valid = (cmd_sr[7:5] == SHT_ADDR) &&
                     ((cmd_sr[4:0] == CMD_TEMP) || (cmd_sr[4:0] == CMD_RH));

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    act     = ACT_NONE;
    if (start_done) begin
      // A completed start restarts reception from any state
      state_d = ST_CMD_RX;
      act     = ACT_START;
    end else begin
      case (state_q)
        ST_CMD_RX:
          if (sck_rise && bit_cnt != 4'd8) begin
            act = ACT_SHIFT;
          end else if (sck_fall && bit_cnt == 4'd8) begin
            if (cmd_valid) begin
              state_d = ST_CMD_ACK;
              act     = ACT_ACCEPT;
            end else begin
              state_d = ST_IDLE;
              act     = ACT_RELEASE;
            end
          end
        ST_CMD_ACK:
          if (sck_fall) begin
            state_d = ST_MEAS;
            act     = ACT_RELEASE;
          end
        ST_MEAS:
          if (meas_cnt == MEAS_CYCLES - 20'd1) begin
            state_d = ST_TX;
            act     = ACT_FIRST_BIT;
          end
        ST_TX:
          if (sck_fall) begin
            if (bit_idx == 3'd0) begin
              state_d = ST_TX_ACK;
              act     = ACT_RELEASE;
            end else begin
              act = ACT_NEXT_BIT;
            end
          end
        ST_TX_ACK:
          if (sck_rise) begin
            act = ACT_SAMPLE_ACK;
          end else if (sck_fall) begin
            // MSB always continues; LSB continues into CRC only on ACK (low)
            if (byte_idx == 2'd0 || (byte_idx == 2'd1 && !ack_level)) begin
              state_d = ST_TX;
              act     = ACT_NEXT_BYTE;
            end else begin
              state_d = ST_IDLE;
              act     = ACT_FINISH;
            end
          end
        default: ;
      endcase
    end
  end

  // ---------------- transmit bit selection and CRC feed ----------------
  logic [1:0] sel_byte;
  logic [2:0] sel_idx;
  logic [7:0] tx_byte, crc;
  logic       tx_bit, crc_clr, crc_en, crc_din;

  always_comb begin
    sel_byte = byte_idx;
    sel_idx  = bit_idx - 3'd1;
    if (act == ACT_FIRST_BIT) begin
      sel_byte = 2'd0;
      sel_idx  = 3'd7;
    end else if (act == ACT_NEXT_BYTE) begin
      sel_byte = byte_idx + 2'd1;
      sel_idx  = 3'd7;
    end
    case (sel_byte)
      2'd0:    tx_byte = word_q[15:8];
      2'd1:    tx_byte = word_q[7:0];
      default: tx_byte = reverse8(crc);
    endcase
    tx_bit = tx_byte[sel_idx];
  end

  // CRC absorbs the 8 command bits as received, then each data bit as it is
  // presented; all 16 are in before the CRC byte is first selected.
  always_comb begin
    crc_clr = (act == ACT_START);
    crc_en  = 1'b0;
    crc_din = 1'b0;
    if (act == ACT_SHIFT) begin
      crc_en  = 1'b1;
      crc_din = sda_s;
    end else if ((act == ACT_FIRST_BIT || act == ACT_NEXT_BIT || act == ACT_NEXT_BYTE)
                 && sel_byte != 2'd2) begin
      crc_en  = 1'b1;
      crc_din = tx_bit;
    end
  end

  sht10_crc8 u_crc (
    .clock (clock),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  // ---------------- datapath ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_sr     <= '0;
      bit_cnt    <= '0;
      word_q     <= '0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      ack_level  <= 1'b1;
      meas_cnt   <= '0;
      drive_q    <= 1'b0;
      accepted_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      accepted_q <= 1'b0;
      done_q     <= 1'b0;
      meas_cnt   <= (state_q == ST_MEAS && state_d == ST_MEAS) ? meas_cnt + 20'd1 : '0;
      case (act)
        ACT_START: begin
          drive_q <= 1'b0;
          bit_cnt <= '0;
        end
        ACT_SHIFT: begin
          cmd_sr  <= {cmd_sr[6:0], sda_s};
          bit_cnt <= bit_cnt + 4'd1;
        end
        ACT_ACCEPT: begin
          drive_q    <= 1'b1;
          word_q     <= (cmd_sr[4:0] == CMD_TEMP) ? {2'b00, temp_value} : {4'b0000, rh_value};
          accepted_q <= 1'b1;
        end
        ACT_RELEASE:    drive_q <= 1'b0;
        ACT_FIRST_BIT: begin
          byte_idx <= 2'd0;
          bit_idx  <= 3'd7;
          drive_q  <= ~tx_bit;
        end
        ACT_NEXT_BIT: begin
          bit_idx <= bit_idx - 3'd1;
          drive_q <= ~tx_bit;
        end
        ACT_SAMPLE_ACK: ack_level <= sda_s;
        ACT_NEXT_BYTE: begin
          byte_idx <= byte_idx + 2'd1;
          bit_idx  <= 3'd7;
          drive_q  <= ~tx_bit;
        end
        ACT_FINISH: begin
          drive_q <= 1'b0;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    busy          = (state_q == ST_CMD_ACK) || (state_q == ST_MEAS) ||
                    (state_q == ST_TX) || (state_q == ST_TX_ACK);
    sda_drive_low = drive_q;
    cmd_accepted  = accepted_q;
    xfer_done     = done_q;
  end

endmodule

// File: tb/tb_sht10_responder.sv
// -----------------------------------------------------------------------------
// tb_sht10_responder
// Drives the SHT10 master side of the 2-wire link and scores the responder.
// Expected events (command accepted, each byte read, read finished) are queued
// when a transaction is issued; a monitor pops them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_sht10_responder;

  localparam int          HP   = 16;       // master SCK half period, clocks
  localparam logic [19:0] MEAS = 20'd200;
  localparam int          SYNC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sck   = 1'b0;
  logic        m_low = 1'b0;
  logic [13:0] temp_value = '0;
  logic [11:0] rh_value   = '0;
  logic        sda_drive_low, busy, cmd_accepted, xfer_done;
  wire         sda = ~(m_low | sda_drive_low);

  always #5 clock = ~clock;

  sht10_responder #(.MEAS_CYCLES(MEAS), .SYNC_STAGES(SYNC)) dut (
    .clock         (clock),
    .reset         (reset),
    .sck_in        (sck),
    .sda_in        (sda),
    .sda_drive_low (sda_drive_low),
    .temp_value    (temp_value),
    .rh_value      (rh_value),
    .busy          (busy),
    .cmd_accepted  (cmd_accepted),
    .xfer_done     (xfer_done)
  );

  // ---------------- scoreboard ----------------
  typedef enum logic [1:0] {EV_ACCEPT, EV_BYTE, EV_DONE} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] rx_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic ev_t mk_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    return e;
  endfunction

  task automatic match_event(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d data %0h, expected no event", got.kind, got.data);
    end else begin
      e = exp_q.pop_front();
      check("event(kind,data)", {22'd0, got}, {22'd0, e});
    end
  endtask

  always @(negedge clock) begin
    if (cmd_accepted === 1'b1) match_event(mk_ev(EV_ACCEPT, 8'h00));
    while (rx_q.size() != 0) match_event(mk_ev(EV_BYTE, rx_q.pop_front()));
    if (xfer_done === 1'b1) match_event(mk_ev(EV_DONE, 8'h00));
  end

  // Reference CRC: remainder of (message * x^8) mod x^8+x^5+x^4+1 by long
  // division over the 24-bit message, then bit-reversed for transmission.
  function automatic logic [7:0] expected_crc(input logic [7:0] cmd, input logic [15:0] data);
    logic [31:0] rem;
    logic [7:0]  r;
    rem = {cmd, data, 8'h00};
    for (int i = 31; i >= 8; i--)
      if (rem[i]) rem = rem ^ (32'h131 << (i - 8));
    for (int i = 0; i < 8; i++) r[i] = rem[7-i];
    return r;
  endfunction

  // ---------------- master-side bus tasks ----------------
  task automatic half();
    repeat (HP) @(posedge clock);
    #1;
  endtask

  task automatic start_seq();
    half(); sck = 1'b1;
    half(); m_low = 1'b1;
    half(); sck = 1'b0;
    half(); sck = 1'b1;
    half(); m_low = 1'b0;
    half(); sck = 1'b0;
    half();
  endtask

  // Sends 8 bits, then clocks the ACK pulse watching DATA across its high phase
  task automatic send_cmd(input logic [7:0] b, output logic all_low, output logic any_low);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i];
      half(); sck = 1'b1;
      half(); sck = 1'b0;
    end
    m_low = 1'b0;
    half(); sck = 1'b1;
    all_low = 1'b1;
    any_low = 1'b0;
    for (int k = 0; k < HP; k++) begin
      @(negedge clock);
      if (sda === 1'b0) any_low = 1'b1;
      else              all_low = 1'b0;
    end
    @(posedge clock); #1;
    sck = 1'b0;
  endtask

  task automatic wait_drive(input logic level, input int limit, output int n);
    n = 0;
    while (sda_drive_low !== level && n < limit) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      half(); sck = 1'b1;
      repeat (HP / 2) @(posedge clock);
      @(negedge clock) b[i] = sda;
      repeat (HP / 2) @(posedge clock);
      #1;
      sck = 1'b0;
    end
    rx_q.push_back(b);
    m_low = give_ack;
    half(); sck = 1'b1;
    half(); sck = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    m_low = 1'b0;
  endtask

  task automatic clock_pulses(input int count);
    for (int i = 0; i < count; i++) begin
      half(); sck = 1'b1;
      half(); sck = 1'b0;
    end
  endtask

  // Full read: optional start, command, ACK, measurement wait, 2 or 3 bytes
  task automatic do_xfer(input logic do_start, input logic is_temp,
                         input logic [13:0] val, input logic nack_lsb);
    logic [15:0] word;
    logic [7:0]  cmd, b;
    logic        all_low, any_low;
    int          n, c;
    cmd = is_temp ? 8'h03 : 8'h05;
    if (is_temp) begin
      temp_value = val;
      word       = {2'b00, val};
    end else begin
      rh_value = val[11:0];
      word     = {4'b0000, val[11:0]};
    end
    exp_q.push_back(mk_ev(EV_ACCEPT, 8'h00));
    exp_q.push_back(mk_ev(EV_BYTE, word[15:8]));
    exp_q.push_back(mk_ev(EV_BYTE, word[7:0]));
    if (!nack_lsb) exp_q.push_back(mk_ev(EV_BYTE, expected_crc(cmd, word)));
    exp_q.push_back(mk_ev(EV_DONE, 8'h00));

    if (do_start) start_seq();
    send_cmd(cmd, all_low, any_low);
    check("cmd_ack_held_low", all_low, 1'b1);
    // Word is already latched; changing inputs now must not reach the read
    temp_value = 14'($urandom);
    rh_value   = 12'($urandom);
    wait_drive(1'b0, 20, n);
    check("ack_release_late", n > SYNC + 2, 1'b0);
    check("busy_in_meas", busy, 1'b1);
    wait_drive(1'b1, int'(MEAS) + 50, c);
    check("meas_cycles", c, MEAS);
    read_byte(1'b1, b);
    read_byte(~nack_lsb, b);
    if (!nack_lsb) read_byte(1'($urandom_range(0, 1)), b);
    repeat (10) @(negedge clock);
    check("busy_after_read", busy, 1'b0);
    check("released_after_read", sda_drive_low, 1'b0);
    half();
  endtask

  task automatic do_invalid(input logic [7:0] cmd);
    logic all_low, any_low;
    start_seq();
    send_cmd(cmd, all_low, any_low);
    check("invalid_cmd_driven", any_low, 1'b0);
    repeat (10) @(negedge clock);
    check("invalid_cmd_busy", busy, 1'b0);
    half();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic all_low, any_low;
    int   n;

    repeat (4) @(posedge clock);
    @(negedge clock);
    check("reset_drive", sda_drive_low, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_cmd_accepted", cmd_accepted, 1'b0);
    check("reset_xfer_done", xfer_done, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    half();

    // Temperature read, full 3 bytes
    do_xfer(1'b1, 1'b1, 14'h1A2B, 1'b0);
    // Humidity read, master NACKs LSB so no CRC byte
    do_xfer(1'b1, 1'b0, 14'h05C3, 1'b1);
    // Invalid command code, then wrong address
    do_invalid(8'h07);
    do_invalid(8'h23);

    // New start in the middle of the MSB of a temperature read
    temp_value = 14'h1A2B;
    exp_q.push_back(mk_ev(EV_ACCEPT, 8'h00));
    start_seq();
    send_cmd(8'h03, all_low, any_low);
    check("midread_cmd_ack", all_low, 1'b1);
    wait_drive(1'b0, 20, n);
    wait_drive(1'b1, int'(MEAS) + 50, n);
    clock_pulses(3);
    half();
    check("midread_msb_bit4_released", sda_drive_low, 1'b0);
    start_seq();
    @(negedge clock);
    check("midread_start_drive", sda_drive_low, 1'b0);
    check("midread_start_busy", busy, 1'b0);
    do_xfer(1'b0, 1'b0, 14'($urandom), 1'b1);

    // One-clock reset during measurement
    temp_value = 14'($urandom);
    exp_q.push_back(mk_ev(EV_ACCEPT, 8'h00));
    start_seq();
    send_cmd(8'h03, all_low, any_low);
    check("reset_case_cmd_ack", all_low, 1'b1);
    wait_drive(1'b0, 20, n);
    repeat (50) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("meas_reset_drive", sda_drive_low, 1'b0);
    check("meas_reset_busy", busy, 1'b0);
    half();
    do_xfer(1'b1, 1'b1, 14'($urandom), 1'($urandom_range(0, 1)));

    // Connection reset sequence, then a full temperature read
    clock_pulses(9);
    do_xfer(1'b1, 1'b1, 14'($urandom), 1'b0);

    // Randomised reads
    for (int i = 0; i < 5; i++)
      do_xfer(1'b1, 1'($urandom_range(0, 1)), 14'($urandom), 1'($urandom_range(0, 1)));

    repeat (20) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
